// File: rtl/pll_lock_monitor.sv
`default_nettype none
// ============================================================================
// Module   : pll_lock_monitor
// Purpose  : Turns the asynchronous PLL `locked` flag into a clean, registered,
//            synchronous active-low reset for the PLL output clock domain.
//            `locked` is synchronised and filtered. After lock is accepted,
//            the downstream reset is held for a settle time. Loss of lock is
//            detected with glitch rejection, and the sequence restarts.
//
// Ports    : clk        in   PLL output clock
//            resetn     in   synchronous active-low reset
//            locked     in   PLL lock flag, asynchronous to clk
//            clear      in   pulse high to clear lock_lost
//            sys_resetn out  registered active-low reset to downstream logic
//            ready      out  high only while the monitor is in RUN
//            lock_lost  out  sticky flag, set on every declared loss of lock
//            loss_count out  saturating count of declared losses
//
// Config   : LOCK_MONITOR_STATS_EN -- when defined, builds the lock_lost /
//            loss_count statistics. When undefined, both outputs are tied to
//            zero and no statistics registers exist.
//
// Revision : 1.0  initial release
// ============================================================================
module pll_lock_monitor #(
    parameter int SYNC_STAGES   = 2,     // >= 2
    parameter int FILTER_CYCLES = 1024,  // >= 1
    parameter int HOLD_CYCLES   = 4096,  // >= 1
    parameter int LOSS_CYCLES   = 16     // >= 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       locked,
    input  logic       clear,
    output logic       sys_resetn,
    output logic       ready,
    output logic       lock_lost,
    output logic [7:0] loss_count
);

    // One down-counter serves FILTER, HOLD and RUN. It is loaded with N-1 and
    // the state advances on the cycle in which it is already zero, so each
    // phase lasts exactly N cycles.
    localparam int c_MAX_AB  = (FILTER_CYCLES > HOLD_CYCLES) ? FILTER_CYCLES : HOLD_CYCLES;
    localparam int c_MAX_CYC = (c_MAX_AB > LOSS_CYCLES) ? c_MAX_AB : LOSS_CYCLES;
    localparam int c_CNT_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;

    localparam logic [c_CNT_W-1:0] c_FILTER_LOAD = c_CNT_W'(FILTER_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LOAD   = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_LOSS_LOAD   = c_CNT_W'(LOSS_CYCLES - 1);

    localparam logic [2:0] c_ST_WAIT_LOCK = 3'd0;
    localparam logic [2:0] c_ST_FILTER    = 3'd1;
    localparam logic [2:0] c_ST_HOLD      = 3'd2;
    localparam logic [2:0] c_ST_RUN       = 3'd3;
    localparam logic [2:0] c_ST_LOST      = 3'd4;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_locked_s;
    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_CNT_W-1:0]     w_cnt_nxt;
    logic                   r_run;

    // ------------------------------------------------------------------------
    // Synchroniser: only the last stage is ever looked at.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], locked};
        end
    end

    assign w_locked_s = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // Sequencer next-state / counter logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_ST_WAIT_LOCK: begin
                // The detecting cycle counts as the first filtered high cycle.
                if (w_locked_s) begin
                    w_state_nxt = c_ST_FILTER;
                    w_cnt_nxt   = c_FILTER_LOAD;
                end
            end
            c_ST_FILTER: begin
                if (!w_locked_s) begin
                    w_state_nxt = c_ST_WAIT_LOCK;
                end else if (r_cnt == '0) begin
                    w_state_nxt = c_ST_HOLD;
                    w_cnt_nxt   = c_HOLD_LOAD;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            c_ST_HOLD: begin
                if (!w_locked_s) begin
                    w_state_nxt = c_ST_WAIT_LOCK;
                end else if (r_cnt == '0) begin
                    w_state_nxt = c_ST_RUN;
                    w_cnt_nxt   = c_LOSS_LOAD;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            c_ST_RUN: begin
                // Any high sample re-arms the loss timer, so only an unbroken
                // low run of LOSS_CYCLES samples declares a loss.
                if (w_locked_s) begin
                    w_cnt_nxt   = c_LOSS_LOAD;
                end else if (r_cnt == '0) begin
                    w_state_nxt = c_ST_LOST;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            c_ST_LOST: begin
                w_state_nxt = c_ST_WAIT_LOCK;
            end
            default: begin
                w_state_nxt = c_ST_WAIT_LOCK;
            end
        endcase
    end

    // The run flag is registered from the next state so that sys_resetn and
    // ready change on the same edge as the state itself, with no
    // combinational path from any input to the outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= c_ST_WAIT_LOCK;
            r_cnt   <= '0;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_run   <= (w_state_nxt == c_ST_RUN);
        end
    end

    assign sys_resetn = r_run;
    assign ready      = r_run;

    // ------------------------------------------------------------------------
    // Loss statistics
    // ------------------------------------------------------------------------
`ifdef LOCK_MONITOR_STATS_EN
    logic       w_enter_lost;
    logic       r_lock_lost;
    logic [7:0] r_loss_count;

    assign w_enter_lost = (w_state_nxt == c_ST_LOST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_lock_lost  <= 1'b0;
            r_loss_count <= 8'd0;
        end else begin
            // A loss in the same cycle as clear must not be dropped.
            if (w_enter_lost) begin
                r_lock_lost <= 1'b1;
            end else if (clear) begin
                r_lock_lost <= 1'b0;
            end
            if (w_enter_lost && (r_loss_count != 8'hFF)) begin
                r_loss_count <= r_loss_count + 8'd1;
            end
        end
    end

    assign lock_lost  = r_lock_lost;
    assign loss_count = r_loss_count;
`else
    logic w_unused_clear;

    assign w_unused_clear = clear;
    assign lock_lost      = 1'b0;
    assign loss_count     = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_lock_monitor
// Purpose  : Directed self-checking bench for pll_lock_monitor with
//            SYNC_STAGES=2, FILTER_CYCLES=8, HOLD_CYCLES=16, LOSS_CYCLES=4.
//            Statistics expectations follow LOCK_MONITOR_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_pll_lock_monitor;

    localparam int c_SYNC = 2;
    localparam int c_FILT = 8;
    localparam int c_HOLD = 16;
    localparam int c_LOSS = 4;

    // Inputs change 1 ns after an edge, so tick 1 is the first sampling edge
    // and the rise lands SYNC+FILTER+HOLD edges after it.
    localparam int c_ACQ_TICKS  = c_SYNC + c_FILT + c_HOLD + 1;  // 27
    localparam int c_LOSS_TICKS = c_SYNC + c_LOSS;                // 6

`ifdef LOCK_MONITOR_STATS_EN
    localparam int c_STATS = 1;
`else
    localparam int c_STATS = 0;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic       locked;
    logic       clear;
    logic       sys_resetn;
    logic       ready;
    logic       lock_lost;
    logic [7:0] loss_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of the statistics
    int   m_losses = 0;
    logic m_lost   = 1'b0;

    pll_lock_monitor #(
        .SYNC_STAGES  (c_SYNC),
        .FILTER_CYCLES(c_FILT),
        .HOLD_CYCLES  (c_HOLD),
        .LOSS_CYCLES  (c_LOSS)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .locked    (locked),
        .clear     (clear),
        .sys_resetn(sys_resetn),
        .ready     (ready),
        .lock_lost (lock_lost),
        .loss_count(loss_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_count();
        int v;
        v = (m_losses > 255) ? 255 : m_losses;
        return (c_STATS != 0) ? 8'(v) : 8'd0;
    endfunction

    function automatic logic exp_lost();
        return (c_STATS != 0) ? m_lost : 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raises locked and counts ticks until sys_resetn is seen high.
    task automatic acquire(output int n, output int bad);
        int k;
        n   = -1;
        bad = 0;
        k   = 0;
        locked = 1'b1;
        while ((n < 0) && (k < 200)) begin
            tick();
            k++;
            if (ready !== sys_resetn) bad++;
            if (sys_resetn === 1'b1) n = k;
        end
    endtask

    // Drops locked and counts ticks until sys_resetn is seen low.
    task automatic lose(output int n);
        int k;
        n = -1;
        k = 0;
        locked = 1'b0;
        while ((n < 0) && (k < 50)) begin
            tick();
            k++;
            if (sys_resetn === 1'b0) n = k;
        end
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        locked = 1'b0;
        clear  = 1'b0;
        tick();
        tick();
        m_losses = 0;
        m_lost   = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if (sys_resetn !== 1'b0) begin n_fail++; $display("FAIL reset_sys_resetn got=%b exp=0", sys_resetn); end
        n_tests++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", ready); end
        n_tests++;
        if (lock_lost !== 1'b0) begin n_fail++; $display("FAIL reset_lock_lost got=%b exp=0", lock_lost); end
        n_tests++;
        if (loss_count !== 8'd0) begin n_fail++; $display("FAIL reset_loss_count got=%0d exp=0", loss_count); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_power_up();
        int n, bad;
        acquire(n, bad);
        n_tests++;
        if (n !== c_ACQ_TICKS) begin n_fail++; $display("FAIL powerup_latency got=%0d exp=%0d", n, c_ACQ_TICKS); end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL powerup_ready_tracks got=%0d exp=0", bad); end
        n_tests++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL powerup_ready got=%b exp=1", ready); end
    endtask

    task automatic test_run_glitch();
        int bad;
        bad = 0;
        locked = 1'b0;
        repeat (3) begin
            tick();
            if ((sys_resetn !== 1'b1) || (ready !== 1'b1)) bad++;
        end
        locked = 1'b1;
        repeat (10) begin
            tick();
            if ((sys_resetn !== 1'b1) || (ready !== 1'b1)) bad++;
        end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL run_glitch_dropped got=%0d exp=0", bad); end
        n_tests++;
        if (loss_count !== exp_count()) begin n_fail++; $display("FAIL run_glitch_count got=%0d exp=%0d", loss_count, exp_count()); end
    endtask

    task automatic test_loss_recovery();
        int n, bad;
        lose(n);
        m_losses++;
        m_lost = 1'b1;
        n_tests++;
        if (n !== c_LOSS_TICKS) begin n_fail++; $display("FAIL loss_latency got=%0d exp=%0d", n, c_LOSS_TICKS); end
        n_tests++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL loss_ready got=%b exp=0", ready); end
        n_tests++;
        if (lock_lost !== exp_lost()) begin n_fail++; $display("FAIL loss_lock_lost got=%b exp=%b", lock_lost, exp_lost()); end
        n_tests++;
        if (loss_count !== exp_count()) begin n_fail++; $display("FAIL loss_count got=%0d exp=%0d", loss_count, exp_count()); end
        // Keep locked low for 10 ticks in total
        repeat (10 - ((n > 0) ? n : 0)) tick();
        acquire(n, bad);
        n_tests++;
        if (n !== c_ACQ_TICKS) begin n_fail++; $display("FAIL recovery_latency got=%0d exp=%0d", n, c_ACQ_TICKS); end
        n_tests++;
        if (lock_lost !== exp_lost()) begin n_fail++; $display("FAIL recovery_sticky got=%b exp=%b", lock_lost, exp_lost()); end
    endtask

    task automatic test_clear();
        clear = 1'b1;
        tick();
        clear  = 1'b0;
        m_lost = 1'b0;
        n_tests++;
        if (lock_lost !== exp_lost()) begin n_fail++; $display("FAIL clear_lock_lost got=%b exp=%b", lock_lost, exp_lost()); end
        n_tests++;
        if (loss_count !== exp_count()) begin n_fail++; $display("FAIL clear_keeps_count got=%0d exp=%0d", loss_count, exp_count()); end
    endtask

    task automatic test_clear_collision();
        int n, bad;
        locked = 1'b0;
        repeat (c_LOSS_TICKS - 1) tick();
        n_tests++;
        if (sys_resetn !== 1'b1) begin n_fail++; $display("FAIL collide_pre_lost got=%b exp=1", sys_resetn); end
        clear = 1'b1;            // sampled on the LOST-entry edge
        tick();
        clear    = 1'b0;
        m_losses++;
        m_lost   = 1'b1;
        n_tests++;
        if (sys_resetn !== 1'b0) begin n_fail++; $display("FAIL collide_lost_entry got=%b exp=0", sys_resetn); end
        n_tests++;
        if (lock_lost !== exp_lost()) begin n_fail++; $display("FAIL collide_set_wins got=%b exp=%b", lock_lost, exp_lost()); end
        tick();
        n_tests++;
        if (lock_lost !== exp_lost()) begin n_fail++; $display("FAIL collide_sticky got=%b exp=%b", lock_lost, exp_lost()); end
        acquire(n, bad);
        n_tests++;
        if (n !== c_ACQ_TICKS) begin n_fail++; $display("FAIL collide_recovery got=%0d exp=%0d", n, c_ACQ_TICKS); end
    endtask

    task automatic test_saturation();
        int n, n2, b2, bad;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            lose(n);
            m_losses++;
            m_lost = 1'b1;
            if (n != c_LOSS_TICKS) bad++;
            acquire(n2, b2);
            if ((n2 != c_ACQ_TICKS) || (b2 != 0)) bad++;
            if (i == 99) begin
                n_tests++;
                if (loss_count !== exp_count()) begin n_fail++; $display("FAIL sat_midway got=%0d exp=%0d", loss_count, exp_count()); end
            end
        end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL sat_sequences got=%0d exp=0", bad); end
        n_tests++;
        if (loss_count !== exp_count()) begin n_fail++; $display("FAIL sat_count got=%0d exp=%0d", loss_count, exp_count()); end
        n_tests++;
        if (lock_lost !== exp_lost()) begin n_fail++; $display("FAIL sat_lock_lost got=%b exp=%b", lock_lost, exp_lost()); end
    endtask

    task automatic test_filter_glitch();
        int n, bad, pre;
        apply_reset();
        resetn = 1'b1;
        tick();
        pre = 0;
        locked = 1'b1;
        repeat (5) begin tick(); if (sys_resetn !== 1'b0) pre++; end
        locked = 1'b0;
        repeat (3) begin tick(); if (sys_resetn !== 1'b0) pre++; end
        acquire(n, bad);
        n_tests++;
        if (pre !== 0) begin n_fail++; $display("FAIL filter_early_release got=%0d exp=0", pre); end
        n_tests++;
        if (n !== c_ACQ_TICKS) begin n_fail++; $display("FAIL filter_latency got=%0d exp=%0d", n, c_ACQ_TICKS); end
    endtask

    task automatic test_reset_mid_hold();
        int n, bad;
        // Get a non-zero statistics state first so the reset is visible
        lose(n);
        m_losses++;
        m_lost = 1'b1;
        repeat (3) tick();
        locked = 1'b1;
        repeat (14) tick();      // HOLD entered on tick 11
        n_tests++;
        if (sys_resetn !== 1'b0) begin n_fail++; $display("FAIL midhold_in_hold got=%b exp=0", sys_resetn); end
        resetn = 1'b0;
        tick();
        m_losses = 0;
        m_lost   = 1'b0;
        n_tests++;
        if ({sys_resetn, ready, lock_lost} !== 3'b000) begin n_fail++; $display("FAIL midhold_reset_flags got=%b exp=000", {sys_resetn, ready, lock_lost}); end
        n_tests++;
        if (loss_count !== 8'd0) begin n_fail++; $display("FAIL midhold_reset_count got=%0d exp=0", loss_count); end
        resetn = 1'b1;
        acquire(n, bad);
        n_tests++;
        if (n !== c_ACQ_TICKS) begin n_fail++; $display("FAIL midhold_restart got=%0d exp=%0d", n, c_ACQ_TICKS); end
        n_tests++;
        if ((lock_lost !== exp_lost()) || (loss_count !== exp_count())) begin
            n_fail++;
            $display("FAIL midhold_stats got=%b/%0d exp=%b/%0d", lock_lost, loss_count, exp_lost(), exp_count());
        end
    endtask

    initial begin
        resetn = 1'b0;
        locked = 1'b0;
        clear  = 1'b0;
        test_reset();
        test_power_up();
        test_run_glitch();
        test_loss_recovery();
        test_clear();
        test_clear_collision();
        test_saturation();
        test_filter_glitch();
        test_reset_mid_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
